// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore-style sequencer for a multi-cycle RV32I datapath that shares a single
// instruction/data memory behind a ready handshake. Supported instructions are
// add/sub/and/or/slt, addi/andi/ori/slti, lw, sw, beq, bne, jal and lui.
// Illegal encodings and memory accesses that never complete drive the FSM into
// an absorbing TRAP state. Only reset leaves that state.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   opcode, funct3,     instruction fields taken from the instruction register
//   funct7_5
//   zero                ALU result == 0, used by beq/bne
//   mem_ready           memory finishes the current access this cycle
//   pc_write, ir_write  PC load; instruction register and old-PC load
//   adr_src             memory address select (0 = PC, 1 = ALUOut)
//   mem_read, mem_write memory requests
//   reg_write           register file write
//   alu_src_a/_b        ALU operand selects
//   result_src          result bus select
//   imm_src             immediate format (I/S/B/J/U)
//   alu_ctrl            ALU operation
//   trap                sticky error flag
//   state_dbg           current state encoding
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int ALU_CTRL_W  = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_CNT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  adr_src,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [2:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  trap,
    output logic [3:0]            state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    // Opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // funct3 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Operand / result selects
    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_RS1   = 2'b10;
    localparam logic [1:0] A_ZERO  = 2'b11;
    localparam logic [1:0] B_RS2   = 2'b00;
    localparam logic [1:0] B_IMM   = 2'b01;
    localparam logic [1:0] B_FOUR  = 2'b10;
    localparam logic [1:0] R_ALUOUT = 2'b00;
    localparam logic [1:0] R_MEM    = 2'b01;
    localparam logic [1:0] R_ALU    = 2'b10;

    // Last counter value before a stalled access is declared dead.
    localparam logic [TO_CNT_W-1:0] TO_LAST =
        TO_CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic [2:0] alu_op;
    } ctrl_t;

    state_t              state;
    state_t              state_next;
    ctrl_t               ctrl;
    logic [TO_CNT_W-1:0] to_cnt;
    logic                trap_q;
    logic                waiting;
    logic                timed_out;

    function automatic logic alu_f3_ok(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_OR) || (f3 == F3_AND);
    endfunction

    // funct7_5 selects sub only for funct3 000; I-type callers pass 0.
    function automatic logic [2:0] alu_op_for(input logic [2:0] f3, input logic sub);
        case (f3)
            F3_ADD:  return sub ? ALU_SUB : ALU_ADD;
            F3_AND:  return ALU_AND;
            F3_OR:   return ALU_OR;
            F3_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // States that stall on the memory handshake and are guarded by the timeout.
    assign waiting   = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timed_out = (MEM_TIMEOUT != 0) && (to_cnt == TO_LAST);

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves a variable unassigned and a latch cannot be inferred.
        ctrl       = '0;
        state_next = state;

        case (state)
            S_FETCH: begin
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src_a  = A_PC;
                ctrl.alu_src_b  = B_FOUR;
                ctrl.result_src = R_ALU;
                ctrl.alu_op     = ALU_ADD;
                // A ready cycle beats a timeout detected in the same cycle.
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_next    = S_DECODE;
                end else if (timed_out) begin
                    state_next = S_TRAP;
                end
            end

            S_DECODE: begin
                // Speculative branch/jump target into ALUOut.
                ctrl.alu_src_a = A_OLDPC;
                ctrl.alu_src_b = B_IMM;
                ctrl.imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                ctrl.alu_op    = ALU_ADD;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = (funct3 == F3_WORD) ? S_MEMADR : S_TRAP;
                    OP_RTYPE:  state_next = alu_f3_ok(funct3) ? S_EXECR : S_TRAP;
                    OP_ITYPE:  state_next = alu_f3_ok(funct3) ? S_EXECI : S_TRAP;
                    OP_BRANCH: state_next = ((funct3 == F3_BEQ) || (funct3 == F3_BNE))
                                            ? S_BRANCH : S_TRAP;
                    OP_JAL:    state_next = S_JAL;
                    OP_LUI:    state_next = S_LUI;
                    default:   state_next = S_TRAP;
                endcase
            end

            S_MEMADR: begin
                ctrl.alu_src_a = A_RS1;
                ctrl.alu_src_b = B_IMM;
                ctrl.alu_op    = ALU_ADD;
                ctrl.imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_next     = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.adr_src  = 1'b1;
                if (mem_ready)      state_next = S_MEMWB;
                else if (timed_out) state_next = S_TRAP;
            end

            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = R_MEM;
                state_next      = S_FETCH;
            end

            S_MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.adr_src   = 1'b1;
                if (mem_ready)      state_next = S_FETCH;
                else if (timed_out) state_next = S_TRAP;
            end

            S_EXECR: begin
                ctrl.alu_src_a = A_RS1;
                ctrl.alu_src_b = B_RS2;
                ctrl.alu_op    = alu_op_for(funct3, funct7_5);
                state_next     = S_ALUWB;
            end

            S_EXECI: begin
                ctrl.alu_src_a = A_RS1;
                ctrl.alu_src_b = B_IMM;
                ctrl.imm_src   = IMM_I;
                ctrl.alu_op    = alu_op_for(funct3, 1'b0);
                state_next     = S_ALUWB;
            end

            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = R_ALUOUT;
                state_next      = S_FETCH;
            end

            S_BRANCH: begin
                ctrl.alu_src_a  = A_RS1;
                ctrl.alu_src_b  = B_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.result_src = R_ALUOUT;
                ctrl.pc_write   = (funct3 == F3_BNE) ? ~zero : zero;
                state_next      = S_FETCH;
            end

            S_JAL: begin
                // PC takes the target computed in DECODE while the ALU forms
                // the link address oldPC + 4 for the following ALUWB.
                ctrl.alu_src_a  = A_OLDPC;
                ctrl.alu_src_b  = B_FOUR;
                ctrl.alu_op     = ALU_ADD;
                ctrl.result_src = R_ALUOUT;
                ctrl.imm_src    = IMM_J;
                ctrl.pc_write   = 1'b1;
                state_next      = S_ALUWB;
            end

            S_LUI: begin
                ctrl.alu_src_a = A_ZERO;
                ctrl.alu_src_b = B_IMM;
                ctrl.imm_src   = IMM_U;
                ctrl.alu_op    = ALU_ADD;
                state_next     = S_ALUWB;
            end

            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state  <= S_FETCH;
            to_cnt <= '0;
            trap_q <= 1'b0;
        end else begin
            state  <= state_next;
            trap_q <= trap_q | (state_next == S_TRAP);
            if ((state_next != state) || mem_ready) begin
                to_cnt <= '0;
            end else if (waiting) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // NOTE: outputs are gated by rst_n combinationally so write enables drop
    // the instant reset asserts, not at the next clock edge.
    assign pc_write   = rst_n & ctrl.pc_write;
    assign ir_write   = rst_n & ctrl.ir_write;
    assign adr_src    = rst_n & ctrl.adr_src;
    assign mem_read   = rst_n & ctrl.mem_read;
    assign mem_write  = rst_n & ctrl.mem_write;
    assign reg_write  = rst_n & ctrl.reg_write;
    assign alu_src_a  = rst_n ? ctrl.alu_src_a  : 2'b00;
    assign alu_src_b  = rst_n ? ctrl.alu_src_b  : 2'b00;
    assign result_src = rst_n ? ctrl.result_src : 2'b00;
    assign imm_src    = rst_n ? ctrl.imm_src    : 3'b000;
    assign alu_ctrl   = rst_n ? ALU_CTRL_W'(ctrl.alu_op) : '0;
    assign trap       = rst_n & trap_q;
    assign state_dbg  = rst_n ? state : S_FETCH;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Directed scenarios for reset, decode, branches, memory stalls, timeout,
// illegal opcodes and asynchronous reset, followed by a randomized stream of
// back-to-back instructions checked against a mnemonic-level reference model.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;
    logic [2:0] alu_ctrl;
    logic       trap;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_control_unit #(
        .ALU_CTRL_W (3),
        .MEM_TIMEOUT(16),
        .TO_CNT_W   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .adr_src   (adr_src),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .result_src(result_src),
        .imm_src   (imm_src),
        .alu_ctrl  (alu_ctrl),
        .trap      (trap),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Observed control word: {pc_write, ir_write, adr_src, mem_read, mem_write,
    // reg_write, alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, trap}.
    logic [5:0]  obs_en;
    logic [18:0] obs_all;
    assign obs_en  = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write};
    assign obs_all = {obs_en, alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, trap};

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum int {
        K_ADD, K_SUB, K_AND, K_OR, K_SLT,
        K_ADDI, K_ANDI, K_ORI, K_SLTI,
        K_LW, K_SW, K_BEQ, K_BNE, K_JAL, K_LUI, K_ILL
    } kind_t;

    int exp_path[$];

    // ---------------------------------------------------------------- model
    task automatic encode(input kind_t k);
        funct7_5 = 1'($urandom_range(0, 1));
        case (k)
            K_ADD:  begin opcode = OP_RTYPE;  funct3 = 3'b000; funct7_5 = 1'b0; end
            K_SUB:  begin opcode = OP_RTYPE;  funct3 = 3'b000; funct7_5 = 1'b1; end
            K_AND:  begin opcode = OP_RTYPE;  funct3 = 3'b111; funct7_5 = 1'b0; end
            K_OR:   begin opcode = OP_RTYPE;  funct3 = 3'b110; funct7_5 = 1'b0; end
            K_SLT:  begin opcode = OP_RTYPE;  funct3 = 3'b010; funct7_5 = 1'b0; end
            K_ADDI: begin opcode = OP_ITYPE;  funct3 = 3'b000; end
            K_ANDI: begin opcode = OP_ITYPE;  funct3 = 3'b111; end
            K_ORI:  begin opcode = OP_ITYPE;  funct3 = 3'b110; end
            K_SLTI: begin opcode = OP_ITYPE;  funct3 = 3'b010; end
            K_LW:   begin opcode = OP_LOAD;   funct3 = 3'b010; end
            K_SW:   begin opcode = OP_STORE;  funct3 = 3'b010; end
            K_BEQ:  begin opcode = OP_BRANCH; funct3 = 3'b000; end
            K_BNE:  begin opcode = OP_BRANCH; funct3 = 3'b001; end
            K_JAL:  begin opcode = OP_JAL;    funct3 = 3'($urandom_range(0, 7)); end
            K_LUI:  begin opcode = OP_LUI;    funct3 = 3'($urandom_range(0, 7)); end
            default: begin
                // Unknown opcodes, plus known opcodes with unsupported funct3.
                case ($urandom_range(0, 6))
                    0: begin opcode = 7'b1110011; funct3 = 3'($urandom_range(0, 7)); end
                    1: begin opcode = 7'b0000000; funct3 = 3'($urandom_range(0, 7)); end
                    2: begin opcode = 7'b1100111; funct3 = 3'b000; end
                    3: begin opcode = OP_BRANCH;  funct3 = 3'($urandom_range(2, 7)); end
                    4: begin opcode = OP_LOAD;    funct3 = 3'b000; end
                    5: begin opcode = OP_RTYPE;   funct3 = 3'b001; end
                    default: begin opcode = OP_ITYPE; funct3 = 3'b100; end
                endcase
            end
        endcase
    endtask

    // Expected state sequence for one instruction (FETCH of the next one excluded).
    task automatic build_path(input kind_t k);
        exp_path = {};
        exp_path.push_back(0);
        exp_path.push_back(1);
        case (k)
            K_ADD, K_SUB, K_AND, K_OR, K_SLT: begin exp_path.push_back(6); exp_path.push_back(8); end
            K_ADDI, K_ANDI, K_ORI, K_SLTI:    begin exp_path.push_back(7); exp_path.push_back(8); end
            K_LW:  begin exp_path.push_back(2); exp_path.push_back(3); exp_path.push_back(4); end
            K_SW:  begin exp_path.push_back(2); exp_path.push_back(5); end
            K_BEQ, K_BNE: exp_path.push_back(9);
            K_JAL: begin exp_path.push_back(10); exp_path.push_back(8); end
            K_LUI: begin exp_path.push_back(11); exp_path.push_back(8); end
            default: exp_path.push_back(15);
        endcase
    endtask

    function automatic logic [2:0] alu_of(input kind_t k);
        case (k)
            K_SUB:          return 3'b001;
            K_AND, K_ANDI:  return 3'b010;
            K_OR,  K_ORI:   return 3'b011;
            K_SLT, K_SLTI:  return 3'b101;
            default:        return 3'b000;
        endcase
    endfunction

    function automatic logic [18:0] model_ctrl(input int s, input kind_t k,
                                               input logic rdy, input logic z);
        logic       pc_w, ir_w, adr, mrd, mwr, rw;
        logic [1:0] a, b, res;
        logic [2:0] imm, alu;
        pc_w = (s == 0 && rdy) || (s == 10) || (s == 9 && ((k == K_BEQ) ? z : !z));
        ir_w = (s == 0 && rdy);
        adr  = (s == 3) || (s == 5);
        mrd  = (s == 0) || (s == 3);
        mwr  = (s == 5);
        rw   = (s == 4) || (s == 8);
        a    = (s == 1 || s == 10) ? 2'b01 :
               (s == 2 || s == 6 || s == 7 || s == 9) ? 2'b10 :
               (s == 11) ? 2'b11 : 2'b00;
        b    = (s == 0 || s == 10) ? 2'b10 :
               (s == 1 || s == 2 || s == 7 || s == 11) ? 2'b01 : 2'b00;
        res  = (s == 0) ? 2'b10 : (s == 4) ? 2'b01 : 2'b00;
        imm  = (s == 1)  ? ((k == K_JAL) ? 3'b011 : 3'b010) :
               (s == 2)  ? ((k == K_SW) ? 3'b001 : 3'b000) :
               (s == 10) ? 3'b011 :
               (s == 11) ? 3'b100 : 3'b000;
        alu  = (s == 9) ? 3'b001 : (s == 6 || s == 7) ? alu_of(k) : 3'b000;
        return {pc_w, ir_w, adr, mrd, mwr, rw, a, b, res, imm, alu, 1'(s == 15)};
    endfunction

    // ---------------------------------------------------------------- helpers
    task automatic apply_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #3;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_ITYPE; funct3 = 3'b000;
        #2;
        n_checks++;
        if (obs_all !== 19'd0 || state_dbg !== 4'd0)
            $display("FAIL reset_outputs: got ctrl=%h state=%0d, want ctrl=0 state=0", obs_all, state_dbg);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (obs_all !== 19'd0)
            $display("FAIL reset_held: got ctrl=%h, want 0", obs_all);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (state_dbg !== 4'd0 ||
            obs_all !== {6'b110100, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 1'b0})
            $display("FAIL reset_fetch: got ctrl=%h state=%0d, want ctrl=%h state=0",
                     obs_all, state_dbg, {6'b110100, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 1'b0});
        else n_pass++;
    endtask

    task automatic test_addi();
        int exp_s[5] = '{0, 1, 7, 8, 0};
        apply_reset();
        opcode = OP_ITYPE; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (state_dbg !== 4'(exp_s[i]) || reg_write !== 1'(exp_s[i] == 8))
                $display("FAIL addi_seq[%0d]: got state=%0d reg_write=%b, want state=%0d reg_write=%b",
                         i, state_dbg, reg_write, exp_s[i], exp_s[i] == 8);
            else n_pass++;
            if (i == 2) begin
                n_checks++;
                if (alu_src_b !== 2'b01)
                    $display("FAIL addi_src_b: got %b, want 01", alu_src_b);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        for (int f = 0; f < 2; f++) begin
            apply_reset();
            opcode = OP_RTYPE; funct3 = 3'b000; funct7_5 = 1'(f); mem_ready = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            #1;
            n_checks++;
            if (state_dbg !== 4'd6 || alu_ctrl !== ((f == 1) ? 3'b001 : 3'b000))
                $display("FAIL rtype_f7_%0d: got state=%0d alu_ctrl=%b, want state=6 alu_ctrl=%b",
                         f, state_dbg, alu_ctrl, (f == 1) ? 3'b001 : 3'b000);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        for (int c = 0; c < 4; c++) begin
            logic is_bne, z;
            is_bne = c[1];
            z      = c[0];
            apply_reset();
            opcode = OP_BRANCH; funct3 = is_bne ? 3'b001 : 3'b000; mem_ready = 1'b1; zero = z;
            @(posedge clk); #1;
            @(posedge clk); #1;
            #1;
            n_checks++;
            if (state_dbg !== 4'd9 || pc_write !== (is_bne ? !z : z))
                $display("FAIL branch_bne%0d_z%0d: got state=%0d pc_write=%b, want state=9 pc_write=%b",
                         is_bne, z, state_dbg, pc_write, is_bne ? !z : z);
            else n_pass++;
            @(posedge clk); #1;
            n_checks++;
            if (state_dbg !== 4'd0)
                $display("FAIL branch_return_%0d: got state=%0d, want 0", c, state_dbg);
            else n_pass++;
        end
    endtask

    task automatic test_lw_stall();
        apply_reset();
        opcode = OP_LOAD; funct3 = 3'b010; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (state_dbg !== 4'd3 || mem_read !== 1'b1 || adr_src !== 1'b1)
                $display("FAIL lw_stall[%0d]: got state=%0d mem_read=%b adr_src=%b, want 3/1/1",
                         i, state_dbg, mem_read, adr_src);
            else n_pass++;
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        #1;
        n_checks++;
        if (state_dbg !== 4'd4 || reg_write !== 1'b1 || result_src !== 2'b01)
            $display("FAIL lw_memwb: got state=%0d reg_write=%b result_src=%b, want 4/1/01",
                     state_dbg, reg_write, result_src);
        else n_pass++;
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_checks++;
            if (state_dbg !== 4'd0)
                $display("FAIL timeout_wait[%0d]: got state=%0d, want 0", i, state_dbg);
            else n_pass++;
            @(posedge clk); #1;
        end
        #1;
        n_checks++;
        if (state_dbg !== 4'd15 || trap !== 1'b1 || obs_en !== 6'd0)
            $display("FAIL timeout_trap: got state=%0d trap=%b en=%b, want 15/1/000000",
                     state_dbg, trap, obs_en);
        else n_pass++;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (state_dbg !== 4'd15 || trap !== 1'b1)
            $display("FAIL trap_absorbing: got state=%0d trap=%b, want 15/1", state_dbg, trap);
        else n_pass++;
        apply_reset();
        #1;
        n_checks++;
        if (state_dbg !== 4'd0 || trap !== 1'b0)
            $display("FAIL trap_cleared: got state=%0d trap=%b, want 0/0", state_dbg, trap);
        else n_pass++;
        // Ready on the final allowed cycle wins over the timeout.
        mem_ready = 1'b0;
        opcode = OP_LUI;
        repeat (15) begin @(posedge clk); #1; end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (state_dbg !== 4'd1 || trap !== 1'b0)
            $display("FAIL timeout_ready_wins: got state=%0d trap=%b, want 1/0", state_dbg, trap);
        else n_pass++;
    endtask

    task automatic test_illegal();
        apply_reset();
        opcode = 7'b1110011; funct3 = 3'b000; mem_ready = 1'b1;
        @(posedge clk); #1;
        #1;
        n_checks++;
        if (state_dbg !== 4'd1)
            $display("FAIL illegal_decode: got state=%0d, want 1", state_dbg);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (state_dbg !== 4'd15 || trap !== 1'b1 || obs_en !== 6'd0)
            $display("FAIL illegal_trap: got state=%0d trap=%b en=%b, want 15/1/000000",
                     state_dbg, trap, obs_en);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        opcode = OP_STORE; funct3 = 3'b010; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state_dbg !== 4'd5 || mem_write !== 1'b1)
            $display("FAIL memwrite_enter: got state=%0d mem_write=%b, want 5/1", state_dbg, mem_write);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_all !== 19'd0 || state_dbg !== 4'd0)
            $display("FAIL async_reset_drop: got ctrl=%h state=%0d, want 0/0", obs_all, state_dbg);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back_random(input int n_instr);
        apply_reset();
        for (int i = 0; i < n_instr; i++) begin
            kind_t k;
            k = kind_t'($urandom_range(0, 15));
            encode(k);
            build_path(k);
            foreach (exp_path[j]) begin
                int   s, waits;
                logic is_wait, rdy, z;
                s       = exp_path[j];
                is_wait = (s == 0) || (s == 3) || (s == 5);
                waits   = is_wait ? int'($urandom_range(0, 4)) : 0;
                for (int c = 0; c <= waits; c++) begin
                    rdy = is_wait ? (c == waits) : 1'($urandom_range(0, 1));
                    z   = 1'($urandom_range(0, 1));
                    mem_ready = rdy;
                    zero      = z;
                    #1;
                    n_checks++;
                    if (state_dbg !== 4'(s) || obs_all !== model_ctrl(s, k, rdy, z))
                        $display("FAIL rand[%0d] kind=%0d: got state=%0d ctrl=%h, want state=%0d ctrl=%h",
                                 i, k, state_dbg, obs_all, s, model_ctrl(s, k, rdy, z));
                    else n_pass++;
                    @(posedge clk); #1;
                end
            end
            if (k == K_ILL) apply_reset();
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype();
        test_branch();
        test_lw_stall();
        test_timeout();
        test_illegal();
        test_async_reset();
        test_back_to_back_random(80);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised successor to the single-cycle control unit: a Moore-style FSM that sequences a multi-cycle RV32I datapath using a single shared instruction/data memory with a ready handshake.
- Decodes R-type (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), lw, sw, beq, bne, jal and lui.
- Drives all datapath enables and muxes.
- Flags illegal opcodes and memory timeouts with a sticky trap.

Parameters:
- ALU_CTRL_W, 3, width of alu_ctrl.
- MEM_TIMEOUT, 16, max cycles waiting for mem_ready before trap; 0 disables the timeout.
- TO_CNT_W, 5, width of the timeout counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instruction[6:0] from the instruction register.
- funct3  in  3  instruction[14:12].
- funct7_5  in  1  instruction[30].
- zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC register load.
- ir_write  out  1  instruction register and old-PC load.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- result_src  out  2  result select: 00 = ALUOut, 01 = mem data, 10 = ALU result.
- imm_src  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- alu_ctrl  out  ALU_CTRL_W  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- trap  out  1  sticky error flag.
- state_dbg  out  4  current state encoding.

Behaviour:
- States and encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, JAL = 10, LUI = 11, TRAP = 15.
- Reset (rst_n low, asynchronous): state goes to FETCH, timeout counter to 0, trap to 0. All outputs are held at 0 while rst_n is low, regardless of clock. FETCH outputs appear combinationally once rst_n rises.
- Reset mid-instruction: abandons the instruction; no write enable may stay high.
- FETCH:
  - Drives mem_read = 1, adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_ctrl = add, result_src = 10.
  - ir_write and pc_write are high only in the cycle mem_ready = 1; the FSM then moves to DECODE.
  - Otherwise the FSM stays in FETCH and the counter increments.
- DECODE:
  - Drives alu_src_a = 01, alu_src_b = 01, imm_src = 010, alu_ctrl = add (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 0110111 -> LUI; anything else -> TRAP.
  - Unsupported funct3 values for a known opcode also go to TRAP.
- MEMADR: rs1 + imm; imm_src = 000 for lw, 001 for sw. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_read = 1, adr_src = 1. Waits for mem_ready as in FETCH, then goes to MEMWB.
- MEMWB: reg_write = 1, result_src = 01, then FETCH.
- MEMWRITE: mem_write = 1, adr_src = 1. Held until mem_ready, then FETCH.
- EXECR:
  - alu_src_a = 10, alu_src_b = 00, then ALUWB.
  - alu_ctrl: funct3 000 gives sub if funct7_5 = 1, else add; 111 = and; 110 = or; 010 = slt.
- EXECI: alu_src_b = 01, imm_src = 000, same funct3 map with funct7_5 ignored, then ALUWB.
- ALUWB: reg_write = 1, result_src = 00, then FETCH.
- BRANCH:
  - alu_src_a = 10, alu_src_b = 00, alu_ctrl = sub, result_src = 00.
  - pc_write = zero for beq (funct3 000), ~zero for bne (funct3 001).
  - Then FETCH.
- JAL:
  - alu_src_a = 01, alu_src_b = 10 (oldPC + 4 into ALUOut), result_src = 00, pc_write = 1, imm_src = 011.
  - Then ALUWB.
  - The DECODE target computation uses imm_src = 011 when the opcode is jal.
- LUI: alu_src_a = 11, alu_src_b = 01, imm_src = 100, then ALUWB.
- Timeout counter:
  - Clears on every state change and whenever mem_ready = 1.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT - 1 in a wait state with no mem_ready, the next state is TRAP.
  - mem_ready arriving in that same cycle wins.
- TRAP: absorbing state; trap = 1 and all enables 0. Exited only by reset.
- Unlisted outputs are 0 in each state.
- Latency with mem_ready tied high: addi/R-type 4 cycles, lw 5, sw 4, beq/bne 3, jal 4, lui 4.

Test Plan:
- Reset, mem_ready = 1, opcode 0010011, funct3 000 -> states 0, 1, 7, 8, 0. reg_write high only in state 8; alu_src_b = 01 in state 7.
- R-type, funct3 000, funct7_5 = 1 -> alu_ctrl = 001 in EXECR. With funct7_5 = 0 -> 000.
- bne, zero = 0 -> pc_write = 1 in BRANCH. bne, zero = 1 -> pc_write = 0. beq -> the opposite in each case. Both return to FETCH after 3 cycles.
- lw with mem_ready low for 3 cycles in MEMREAD -> mem_read held high and adr_src = 1 throughout. MEMWB follows the ready cycle; reg_write = 1 with result_src = 01.
- mem_ready held low in FETCH with MEM_TIMEOUT = 16 -> TRAP after 16 cycles, trap = 1, all enables 0. rst_n pulse -> FETCH, trap = 0.
- Opcode 1110011 -> TRAP after DECODE. rst_n low asynchronously during MEMWRITE -> mem_write drops immediately, before the next edge.
